// File: rtl/pso_req_ctrl.sv
// ---------------------------------------------------------------------------
// pso_req_ctrl
//
// Power-shutoff request controller for one switchable module. Decides when
// the module should enter power shutoff (software-forced or after an idle
// window) and when it should leave it (wake event or removal of the entry
// cause). Drives the L1 request into the module's power-control sequencer
// and tracks the sequencer's set/clear status pulses.
//
// Ports
//   pclk               clock, all state changes on the rising edge
//   prst               synchronous active-high reset
//   sw_pso_en          enables automatic (idle-driven) shutoff
//   sw_pso_req         software-forced shutoff, level
//   idle_thresh        idle cycles before an automatic request
//   module_busy        module activity indication
//   wake_evt           wake event sources (level or pulse)
//   wake_mask          1 = wake source enabled
//   wake_clr           write-1-to-clear for wake_pending
//   set_status_module  sequencer pulse: shutoff sequence started
//   clr_status_module  sequencer pulse: power-up sequence finished
//   L1_module_req      shutoff request to the sequencer
//   l1_status          module is in L1 (tracks sequencer pulses)
//   wake_pending       latched masked wake events
//   pso_busy           request/off/wake sequence in flight
//   err_proto          sticky sequencer protocol error
// ---------------------------------------------------------------------------
module pso_req_ctrl #(
  parameter int IDLE_W = 8,
  parameter int WAKE_W = 4
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              sw_pso_en,
  input  logic              sw_pso_req,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              module_busy,
  input  logic [WAKE_W-1:0] wake_evt,
  input  logic [WAKE_W-1:0] wake_mask,
  input  logic [WAKE_W-1:0] wake_clr,
  input  logic              set_status_module,
  input  logic              clr_status_module,
  output logic              L1_module_req,
  output logic              l1_status,
  output logic [WAKE_W-1:0] wake_pending,
  output logic              pso_busy,
  output logic              err_proto
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_IDLE_CNT = 3'd1,
    ST_REQ      = 3'd2,
    ST_OFF      = 3'd3,
    ST_WAKE     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                src_sw_q, src_sw_d;      // 1: entry was software-forced
  logic                l1_status_q, l1_status_d;
  logic [WAKE_W-1:0]   wake_pending_q, wake_pending_d;
  logic                err_proto_q, err_proto_d;

  logic                wk;
  logic                cause_gone;

  // Wake decisions use the latched (registered) pending bits, so a wake
  // event takes one edge to latch and a second edge to move the FSM.
  assign wk = |wake_pending_q;

  // The condition that put us into OFF has been withdrawn.
  assign cause_gone = src_sw_q ? ~sw_pso_req : ~sw_pso_en;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    src_sw_d   = src_sw_q;

    case (state_q)
      ST_RUN: begin
        if (sw_pso_req) begin
          state_d  = ST_REQ;
          src_sw_d = 1'b1;
        end else if (sw_pso_en && !module_busy && !wk) begin
          state_d    = ST_IDLE_CNT;
          idle_cnt_d = '0;
        end
      end

      ST_IDLE_CNT: begin
        if (module_busy || !sw_pso_en || wk) begin
          state_d = ST_RUN;
        end else if (sw_pso_req) begin
          state_d  = ST_REQ;
          src_sw_d = 1'b1;
        end else if (idle_cnt_q == idle_thresh) begin
          state_d  = ST_REQ;
          src_sw_d = 1'b0;
        end else if (idle_cnt_q != '1) begin
          // Saturate: if idle_thresh is lowered below the running count the
          // counter must not wrap around and hit the new threshold later.
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      // No abort path once the request is issued; wake events only latch.
      ST_REQ: begin
        if (set_status_module) begin
          state_d = ST_OFF;
        end
      end

      ST_OFF: begin
        if (wk || cause_gone) begin
          state_d = ST_WAKE;
        end
      end

      ST_WAKE: begin
        if (clr_status_module) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Status, wake latch and protocol error
  // -------------------------------------------------------------------------
  always_comb begin
    l1_status_d = l1_status_q;
    err_proto_d = err_proto_q;

    // Clear has priority when both pulses arrive together.
    if (clr_status_module) begin
      l1_status_d = 1'b0;
    end else if (set_status_module) begin
      l1_status_d = 1'b1;
    end

    if (set_status_module && clr_status_module) begin
      err_proto_d = 1'b1;
    end
    if (set_status_module && (state_q != ST_REQ)) begin
      err_proto_d = 1'b1;
    end
    if (clr_status_module && (state_q != ST_WAKE)) begin
      err_proto_d = 1'b1;
    end

    // New events win over a same-cycle clear of the same bit.
    wake_pending_d = (wake_pending_q & ~wake_clr) | (wake_evt & wake_mask);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q        <= ST_RUN;
      idle_cnt_q     <= '0;
      src_sw_q       <= 1'b0;
      l1_status_q    <= 1'b0;
      wake_pending_q <= '0;
      err_proto_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      src_sw_q       <= src_sw_d;
      l1_status_q    <= l1_status_d;
      wake_pending_q <= wake_pending_d;
      err_proto_q    <= err_proto_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: registers or decodes of registered state only
  // -------------------------------------------------------------------------
  assign L1_module_req = (state_q == ST_REQ) || (state_q == ST_OFF);
  assign pso_busy      = (state_q == ST_REQ) || (state_q == ST_OFF) ||
                         (state_q == ST_WAKE);
  assign l1_status     = l1_status_q;
  assign wake_pending  = wake_pending_q;
  assign err_proto     = err_proto_q;

endmodule

// File: tb/tb_pso_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pso_req_ctrl
//
// Self-checking bench for pso_req_ctrl: directed scenario tasks with
// constant expectations, plus a randomized run compared cycle by cycle
// against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_pso_req_ctrl;

  localparam int IDLE_W = 8;
  localparam int WAKE_W = 4;

  logic              pclk = 1'b0;
  logic              prst;
  logic              sw_pso_en;
  logic              sw_pso_req;
  logic [IDLE_W-1:0] idle_thresh;
  logic              module_busy;
  logic [WAKE_W-1:0] wake_evt;
  logic [WAKE_W-1:0] wake_mask;
  logic [WAKE_W-1:0] wake_clr;
  logic              set_status_module;
  logic              clr_status_module;
  logic              L1_module_req;
  logic              l1_status;
  logic [WAKE_W-1:0] wake_pending;
  logic              pso_busy;
  logic              err_proto;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 pclk = ~pclk;

  pso_req_ctrl #(.IDLE_W(IDLE_W), .WAKE_W(WAKE_W)) dut (
    .pclk              (pclk),
    .prst              (prst),
    .sw_pso_en         (sw_pso_en),
    .sw_pso_req        (sw_pso_req),
    .idle_thresh       (idle_thresh),
    .module_busy       (module_busy),
    .wake_evt          (wake_evt),
    .wake_mask         (wake_mask),
    .wake_clr          (wake_clr),
    .set_status_module (set_status_module),
    .clr_status_module (clr_status_module),
    .L1_module_req     (L1_module_req),
    .l1_status         (l1_status),
    .wake_pending      (wake_pending),
    .pso_busy          (pso_busy),
    .err_proto         (err_proto)
  );

  // Observed outputs packed as {L1_module_req, l1_status, wake_pending, pso_busy, err_proto}
  logic [7:0] dut_vec;
  assign dut_vec = {L1_module_req, l1_status, wake_pending, pso_busy, err_proto};

  // -------------------------------------------------------------------------
  // Behavioural model: phases of the shutoff life cycle
  // -------------------------------------------------------------------------
  localparam int P_ON = 0, P_COUNTING = 1, P_ASKING = 2, P_DOWN = 3, P_WAKING = 4;
  int         m_phase;
  int         m_idle;
  bit         m_forced;
  bit         m_l1;
  bit         m_err;
  logic [3:0] m_wp;

  task automatic model_step();
    int  nphase;
    int  nidle;
    bit  nforced;
    bit  wk;
    if (prst) begin
      m_phase = P_ON; m_idle = 0; m_forced = 0;
      m_l1 = 0; m_err = 0; m_wp = 4'b0;
      return;
    end
    wk      = (m_wp != 4'b0);
    nphase  = m_phase;
    nidle   = m_idle;
    nforced = m_forced;
    if (m_phase == P_ON) begin
      if (sw_pso_req) begin nphase = P_ASKING; nforced = 1; end
      else if (sw_pso_en && !module_busy && !wk) begin nphase = P_COUNTING; nidle = 0; end
    end else if (m_phase == P_COUNTING) begin
      if (module_busy || !sw_pso_en || wk) nphase = P_ON;
      else if (sw_pso_req) begin nphase = P_ASKING; nforced = 1; end
      else if (m_idle == int'(idle_thresh)) begin nphase = P_ASKING; nforced = 0; end
      else nidle = (m_idle >= 255) ? 255 : m_idle + 1;
    end else if (m_phase == P_ASKING) begin
      if (set_status_module) nphase = P_DOWN;
    end else if (m_phase == P_DOWN) begin
      if (wk || (m_forced ? !sw_pso_req : !sw_pso_en)) nphase = P_WAKING;
    end else begin
      if (clr_status_module) nphase = P_ON;
    end
    if (set_status_module && clr_status_module) m_err = 1;
    if (set_status_module && m_phase != P_ASKING) m_err = 1;
    if (clr_status_module && m_phase != P_WAKING) m_err = 1;
    if (clr_status_module) m_l1 = 0;
    else if (set_status_module) m_l1 = 1;
    m_wp     = (m_wp & ~wake_clr) | (wake_evt & wake_mask);
    m_phase  = nphase;
    m_idle   = nidle;
    m_forced = nforced;
  endtask

  function automatic logic [7:0] model_vec();
    bit req;
    bit bsy;
    req = (m_phase == P_ASKING) || (m_phase == P_DOWN);
    bsy = req || (m_phase == P_WAKING);
    return {req, m_l1, m_wp, bsy, m_err};
  endfunction

  // One clock edge; model advances with the DUT, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge pclk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    prst = 0; sw_pso_en = 0; sw_pso_req = 0; idle_thresh = '0;
    module_busy = 0; wake_evt = '0; wake_mask = '0; wake_clr = '0;
    set_status_module = 0; clr_status_module = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    prst = 1;
    tick();
    prst = 0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    wake_evt = 4'hF; wake_mask = 4'hF; sw_pso_req = 1;
    prst = 1;
    tick();
    n_checks++;
    if (dut_vec !== 8'h00) $display("FAIL reset_values got %b expected %b", dut_vec, 8'h00);
    else n_pass++;
    prst = 0; wake_evt = '0; wake_mask = '0; sw_pso_req = 0;
  endtask

  task automatic test_auto_entry();
    do_reset();
    sw_pso_en = 1; idle_thresh = 8'd5;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_checks++;
      if (L1_module_req !== 1'(k >= 7))
        $display("FAIL auto_entry edge %0d L1_module_req=%b expected %b", k, L1_module_req, 1'(k >= 7));
      else n_pass++;
    end
    set_status_module = 1;
    tick();
    set_status_module = 0;
    n_checks++;
    if ({L1_module_req, l1_status, pso_busy, err_proto} !== 4'b1110)
      $display("FAIL auto_off {req,l1,busy,err}=%b expected 1110",
               {L1_module_req, l1_status, pso_busy, err_proto});
    else n_pass++;
  endtask

  task automatic test_busy_abort();
    do_reset();
    sw_pso_en = 1; idle_thresh = 8'd10;
    // Edge 1 enters counting; busy sampled at edge 6 (count 4) aborts;
    // edge 7 restarts, fresh window completes at edge 18.
    for (int k = 1; k <= 18; k++) begin
      module_busy = (k == 6);
      tick();
      n_checks++;
      if (L1_module_req !== 1'(k >= 18))
        $display("FAIL busy_abort edge %0d L1_module_req=%b expected %b", k, L1_module_req, 1'(k >= 18));
      else n_pass++;
    end
    module_busy = 0;
  endtask

  task automatic test_idle_saturation();
    do_reset();
    sw_pso_en = 1; idle_thresh = 8'd200;
    for (int k = 0; k < 30; k++) tick();
    idle_thresh = 8'd20;               // now below the running count
    for (int k = 0; k < 300; k++) tick();
    n_checks++;
    if (L1_module_req !== 1'b0) $display("FAIL idle_saturate_no_wrap L1_module_req=%b expected 0", L1_module_req);
    else n_pass++;
    idle_thresh = 8'd255;              // saturated count matches all-ones
    tick();
    n_checks++;
    if (L1_module_req !== 1'b1) $display("FAIL idle_saturate_hit L1_module_req=%b expected 1", L1_module_req);
    else n_pass++;
  endtask

  task automatic test_wake_off();
    do_reset();
    sw_pso_en = 1; idle_thresh = 8'd0; wake_mask = 4'b0010;
    tick(); tick();
    set_status_module = 1; tick(); set_status_module = 0;
    wake_evt = 4'b0011;
    tick();
    wake_evt = 4'b0000;
    n_checks++;
    if ({L1_module_req, wake_pending} !== 5'b1_0010)
      $display("FAIL wake_latch {req,pending}=%b expected 10010", {L1_module_req, wake_pending});
    else n_pass++;
    tick();
    n_checks++;
    if ({L1_module_req, pso_busy} !== 2'b01)
      $display("FAIL wake_exit {req,busy}=%b expected 01", {L1_module_req, pso_busy});
    else n_pass++;
    clr_status_module = 1; tick(); clr_status_module = 0;
    n_checks++;
    if ({l1_status, pso_busy, err_proto} !== 3'b000)
      $display("FAIL wake_clr_status {l1,busy,err}=%b expected 000", {l1_status, pso_busy, err_proto});
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (L1_module_req !== 1'b0) $display("FAIL wake_blocks_auto cycle %0d L1_module_req=%b expected 0", k, L1_module_req);
      else n_pass++;
    end
    wake_clr = 4'b0010; tick(); wake_clr = 4'b0000;
    n_checks++;
    if (wake_pending !== 4'b0000) $display("FAIL wake_w1c wake_pending=%b expected 0000", wake_pending);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (L1_module_req !== 1'b1) $display("FAIL wake_reentry L1_module_req=%b expected 1", L1_module_req);
    else n_pass++;
  endtask

  task automatic test_forced();
    do_reset();
    sw_pso_req = 1;
    tick();
    n_checks++;
    if (L1_module_req !== 1'b1) $display("FAIL forced_req L1_module_req=%b expected 1", L1_module_req);
    else n_pass++;
    set_status_module = 1; tick(); set_status_module = 0;
    for (int k = 0; k < 20; k++) tick();
    n_checks++;
    if ({L1_module_req, l1_status, pso_busy} !== 3'b111)
      $display("FAIL forced_hold {req,l1,busy}=%b expected 111", {L1_module_req, l1_status, pso_busy});
    else n_pass++;
    sw_pso_req = 0;
    tick();
    n_checks++;
    if ({L1_module_req, pso_busy} !== 2'b01)
      $display("FAIL forced_release {req,busy}=%b expected 01", {L1_module_req, pso_busy});
    else n_pass++;
    clr_status_module = 1; tick(); clr_status_module = 0;
    n_checks++;
    if ({l1_status, pso_busy, err_proto} !== 3'b000)
      $display("FAIL forced_powerup {l1,busy,err}=%b expected 000", {l1_status, pso_busy, err_proto});
    else n_pass++;
  endtask

  task automatic test_proto_err();
    do_reset();
    set_status_module = 1; clr_status_module = 1;
    tick();
    set_status_module = 0; clr_status_module = 0;
    n_checks++;
    if ({l1_status, err_proto, pso_busy} !== 3'b010)
      $display("FAIL proto_both {l1,err,busy}=%b expected 010", {l1_status, err_proto, pso_busy});
    else n_pass++;
    do_reset();
    clr_status_module = 1; tick(); clr_status_module = 0;
    n_checks++;
    if ({err_proto, L1_module_req, pso_busy} !== 3'b100)
      $display("FAIL proto_clr_in_run {err,req,busy}=%b expected 100", {err_proto, L1_module_req, pso_busy});
    else n_pass++;
    sw_pso_req = 1; tick(); sw_pso_req = 0;
    n_checks++;
    if (L1_module_req !== 1'b1) $display("FAIL proto_still_run L1_module_req=%b expected 1", L1_module_req);
    else n_pass++;
    do_reset();
    set_status_module = 1; tick(); set_status_module = 0;
    n_checks++;
    if ({l1_status, err_proto, L1_module_req} !== 3'b110)
      $display("FAIL proto_set_in_run {l1,err,req}=%b expected 110", {l1_status, err_proto, L1_module_req});
    else n_pass++;
  endtask

  task automatic test_reset_mid_off();
    do_reset();
    clr_status_module = 1; tick(); clr_status_module = 0;
    sw_pso_req = 1; tick();
    set_status_module = 1; tick(); set_status_module = 0;
    n_checks++;
    if ({L1_module_req, l1_status, err_proto} !== 3'b111)
      $display("FAIL reset_mid_off_pre {req,l1,err}=%b expected 111", {L1_module_req, l1_status, err_proto});
    else n_pass++;
    prst = 1; wake_evt = 4'hF; wake_mask = 4'hF;
    tick();
    n_checks++;
    if (dut_vec !== 8'h00) $display("FAIL reset_mid_off got %b expected %b", dut_vec, 8'h00);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      prst              = ($urandom_range(0, 199) == 0);
      sw_pso_en         = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) sw_pso_req = ~sw_pso_req;
      if ($urandom_range(0, 49) == 0) idle_thresh = IDLE_W'($urandom_range(0, 6));
      module_busy       = ($urandom_range(0, 5) == 0);
      wake_evt          = ($urandom_range(0, 11) == 0) ? WAKE_W'($urandom) : '0;
      if ($urandom_range(0, 99) == 0) wake_mask = WAKE_W'($urandom);
      wake_clr          = ($urandom_range(0, 5) == 0) ? WAKE_W'($urandom) : '0;
      set_status_module = ($urandom_range(0, 5) == 0);
      clr_status_module = ($urandom_range(0, 5) == 0);
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        if (errs < 10)
          $display("FAIL random cycle %0d {req,l1,pending,busy,err} got %b expected %b", k, dut_vec, model_vec());
        errs++;
      end else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_auto_entry();
    test_busy_abort();
    test_idle_saturation();
    test_wake_off();
    test_forced();
    test_proto_err();
    test_reset_mid_off();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
